proc_run_sequencer: RTL
=======================

PROC_RUN_SEQUENCER -- requirements
Module: proc_run_sequencer

Interface
REQ-001 Parameter: RESET_CYCLES, default 2, number of cycles resetl is held low before each run (legal range 1..255).
REQ-002 Parameter: WATCHDOG_LIMIT, default 16'h00FF, maximum number of RUN cycles before a run is aborted (legal range 1..65535).
REQ-003 CLK  input  1  the single clock; all state changes on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-005 start  input  1  request to launch one program run; sampled in IDLE only.
REQ-006 startAddr  input  64  program start PC, latched on an accepted start.
REQ-007 endAddr  input  64  terminating PC, latched on an accepted start.
REQ-008 expected  input  64  expected MemtoRegOut value, latched on an accepted start.
REQ-009 currentpc  input  64  PC reported by the single-cycle processor.
REQ-010 MemtoRegOut  input  64  writeback value reported by the processor.
REQ-011 resetl  output  1  active-low processor reset, registered.
REQ-012 startpc  output  64  processor start PC, registered, equals the latched startAddr.
REQ-013 busy  output  1  high in HOLD, RUN and DONE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 pass  output  1  result of the completed run; valid only while done=1.
REQ-016 timeout  output  1  run aborted by watchdog; valid only while done=1.
REQ-017 cycleCount  output  16  RUN cycles of the current or last run.
REQ-018 runCount / passCount  output  8 each  completed runs / passing runs.

Function
REQ-019 The FSM SHALL have the states IDLE, HOLD, RUN and DONE.
REQ-020 In IDLE, resetl SHALL be 0; when start=1, the block SHALL latch startAddr, endAddr and expected, clear the hold counter, and enter HOLD.
REQ-021 In HOLD, resetl SHALL be 0 and startpc SHALL equal the latched start address; after exactly RESET_CYCLES HOLD cycles the block SHALL enter RUN, set resetl=1 and clear cycleCount.
REQ-022 In RUN, resetl SHALL be 1 and cycleCount SHALL increment by 1 per cycle, saturating at 16'hFFFF.
REQ-023 In RUN, if currentpc >= the latched endAddr (unsigned 64-bit compare), the block SHALL register pass = (MemtoRegOut == expected) and timeout=0, then enter DONE.
REQ-024 In RUN, if the end condition is false and cycleCount == WATCHDOG_LIMIT-1, the block SHALL register pass=0 and timeout=1, then enter DONE.
REQ-025 When both conditions are true in the same cycle, the end condition SHALL take priority: timeout=0 and pass is evaluated.
REQ-026 In DONE, the block SHALL drive done=1 for exactly one cycle with resetl=0, increment runCount, and increment passCount if pass=1, then enter IDLE.
REQ-027 runCount and passCount SHALL saturate at 8'hFF and SHALL NOT wrap.
REQ-028 A start asserted in HOLD, RUN or DONE SHALL be ignored and SHALL NOT be queued; a start held high continuously SHALL relaunch in the first IDLE cycle after DONE.
REQ-029 cycleCount SHALL hold its final value from DONE until the next HOLD-to-RUN transition.
REQ-030 Latency: from an accepted start to the first cycle with resetl=1 SHALL be RESET_CYCLES+1 cycles.

Reset
REQ-031 While Reset=1, the block SHALL force: state=IDLE, resetl=0, startpc=0, busy=0, done=0, pass=0, timeout=0, cycleCount=0, runCount=0, passCount=0, and all latched operands=0.
REQ-032 Reset asserted in any state, including mid-RUN, SHALL abort the run without a done pulse and without counter updates.
REQ-033 While Reset=1, start SHALL be ignored.

Verification
REQ-034 Processor model increments PC by 4 from startpc and drives MemtoRegOut=0xF at PC 0x30; start with startAddr=0, endAddr=0x30, expected=0xF -> resetl low 2 cycles, done with pass=1, timeout=0, cycleCount=12, runCount=1, passCount=1.
REQ-035 Second run: startAddr=0x30, endAddr=0x5C, expected=0x123456789abcdef0, model drives that value at 0x5C -> pass=1, runCount=2, passCount=2.
REQ-036 Model PC stuck at 0x10, endAddr=0x30, WATCHDOG_LIMIT=0xFF -> done after exactly 255 RUN cycles with timeout=1 and pass=0; passCount unchanged.
REQ-037 Wrong value (MemtoRegOut=0xE at PC 0x30, expected=0xF) -> done with pass=0 and timeout=0; runCount increments and passCount does not.
REQ-038 Reset pulsed mid-RUN at cycleCount=5 -> no done pulse; all outputs reach their reset values with resetl=0; a following start completes normally.
REQ-039 start pulsed during RUN, and WATCHDOG_LIMIT=12 with the end condition reached on cycle 12 -> the extra start is ignored, a single done occurs, and timeout=0.

Source files
------------

// File: rtl/proc_run_sequencer_if.sv
// Bundle between the run sequencer and its host/processor: run request,
// operands, processor observation and run status.
interface proc_run_sequencer_if;
   localparam int unsigned XLEN = 64;
   localparam int unsigned CW   = 16;
   localparam int unsigned RW   = 8;

   logic            start;
   logic [XLEN-1:0] startAddr;
   logic [XLEN-1:0] endAddr;
   logic [XLEN-1:0] expected;
   logic [XLEN-1:0] currentpc;
   logic [XLEN-1:0] MemtoRegOut;
   logic            resetl;
   logic [XLEN-1:0] startpc;
   logic            busy;
   logic            done;
   logic            pass;
   logic            timeout;
   logic [CW-1:0]   cycleCount;
   logic [RW-1:0]   runCount;
   logic [RW-1:0]   passCount;

   modport slave (
      input  start, startAddr, endAddr, expected, currentpc, MemtoRegOut,
      output resetl, startpc, busy, done, pass, timeout, cycleCount, runCount, passCount
   );

   modport master (
      output start, startAddr, endAddr, expected, currentpc, MemtoRegOut,
      input  resetl, startpc, busy, done, pass, timeout, cycleCount, runCount, passCount
   );
endinterface

// File: rtl/proc_run_sequencer.sv
// Launches one program run on a single-cycle processor: holds it in reset,
// releases it, watches for the end PC or a watchdog expiry, and scores the result.
module proc_run_sequencer #(
   parameter int unsigned RESET_CYCLES   = 2,
   parameter int unsigned WATCHDOG_LIMIT = 16'h00FF
) (
   input logic                 CLK,
   input logic                 Reset,
   proc_run_sequencer_if.slave bus
);
   localparam int unsigned XLEN = 64;
   localparam int unsigned CW   = 16;
   localparam int unsigned RW   = 8;
   localparam int unsigned HW   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] start_addr_q, start_addr_d;
   logic [XLEN-1:0] end_addr_q, end_addr_d;
   logic [XLEN-1:0] expected_q, expected_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [CW-1:0]   cycle_count_q, cycle_count_d;
   logic [RW-1:0]   run_count_q, run_count_d;
   logic [RW-1:0]   pass_count_q, pass_count_d;
   logic            pass_q, pass_d;
   logic            timeout_q, timeout_d;
   logic            resetl_q, resetl_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic end_hit_c;
   logic wd_hit_c;
   logic hold_last_c;

   assign end_hit_c   = bus.currentpc >= end_addr_q;
   assign wd_hit_c    = cycle_count_q == CW'(WATCHDOG_LIMIT - 1);
   assign hold_last_c = hold_cnt_q == HW'(RESET_CYCLES - 1);

   // State register
   always_ff @(posedge CLK) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; the end condition outranks the watchdog
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.start)             state_d = HOLD;
         HOLD: if (hold_last_c)           state_d = RUN;
         RUN:  if (end_hit_c || wd_hit_c) state_d = DONE;
         DONE:                            state_d = IDLE;
         default:                         state_d = IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      start_addr_d  = start_addr_q;
      end_addr_d    = end_addr_q;
      expected_d    = expected_q;
      hold_cnt_d    = hold_cnt_q;
      cycle_count_d = cycle_count_q;
      run_count_d   = run_count_q;
      pass_count_d  = pass_count_q;
      pass_d        = pass_q;
      timeout_d     = timeout_q;
      resetl_d      = (state_d == RUN);
      busy_d        = (state_d != IDLE);
      done_d        = (state_d == DONE);
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               start_addr_d = bus.startAddr;
               end_addr_d   = bus.endAddr;
               expected_d   = bus.expected;
               hold_cnt_d   = '0;
            end
         end
         HOLD: begin
            hold_cnt_d = hold_cnt_q + HW'(1);
            if (hold_last_c) cycle_count_d = '0;
         end
         RUN: begin
            if (end_hit_c) begin
               pass_d    = (bus.MemtoRegOut == expected_q);
               timeout_d = 1'b0;
            end else if (wd_hit_c) begin
               pass_d    = 1'b0;
               timeout_d = 1'b1;
            end else if (cycle_count_q != {CW{1'b1}}) begin
               cycle_count_d = cycle_count_q + CW'(1);
            end
         end
         DONE: begin
            if (run_count_q != {RW{1'b1}}) run_count_d = run_count_q + RW'(1);
            if (pass_q && (pass_count_q != {RW{1'b1}})) pass_count_d = pass_count_q + RW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         start_addr_q  <= '0;
         end_addr_q    <= '0;
         expected_q    <= '0;
         hold_cnt_q    <= '0;
         cycle_count_q <= '0;
         run_count_q   <= '0;
         pass_count_q  <= '0;
         pass_q        <= 1'b0;
         timeout_q     <= 1'b0;
         resetl_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         start_addr_q  <= start_addr_d;
         end_addr_q    <= end_addr_d;
         expected_q    <= expected_d;
         hold_cnt_q    <= hold_cnt_d;
         cycle_count_q <= cycle_count_d;
         run_count_q   <= run_count_d;
         pass_count_q  <= pass_count_d;
         pass_q        <= pass_d;
         timeout_q     <= timeout_d;
         resetl_q      <= resetl_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign bus.resetl     = resetl_q;
   assign bus.startpc    = start_addr_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.timeout    = timeout_q;
   assign bus.cycleCount = cycle_count_q;
   assign bus.runCount   = run_count_q;
   assign bus.passCount  = pass_count_q;
endmodule
